adder_pipe: RTL and testbench
=============================

# adder_pipe

Parametrised, pipelined add/subtract unit with registered outputs, the successor to the fixed 4-bit registered adder. The carry chain is split into `STAGES` equal chunks, one per pipeline stage. Each operation carries its own mode and valid flag, so a new operation can be issued every enabled cycle. Unsigned/signed overflow reporting and optional saturation are provided. The unit sits in the datapath wherever a wide registered adder would otherwise limit clock frequency.

## Interface
- `WIDTH`, 8: operand/result width in bits; ≥ 2.
- `STAGES`, 2: pipeline depth; 1 ≤ STAGES ≤ WIDTH, WIDTH % STAGES == 0; chunk width CW = WIDTH/STAGES.
- `SATURATE`, 0: 1 = clamp Sum on overflow; 0 = wrap.

One clock; reset is asynchronous and active-low.

- `Clk` in 1: clock, rising edge.
- `Rst_n` in 1: asynchronous active-low reset.
- `En` in 1: pipeline advance; 0 freezes every register.
- `InValid` in 1: A/B/Sub/Signed carry an operation.
- `A` in WIDTH: operand A.
- `B` in WIDTH: operand B.
- `Sub` in 1: 0 = A+B, 1 = A−B.
- `Signed` in 1: 0 = unsigned, 1 = two's-complement overflow rules.
- `OutValid` out 1: Sum/Carry/Overflow hold a new result this cycle.
- `Sum` out WIDTH: result.
- `Carry` out 1: raw carry-out of bit WIDTH−1 (for Sub, 1 = no borrow).
- `Overflow` out 1: result out of range for the selected mode.

## Operation
- Operation computes A + (Sub ? ~B : B) + Sub.
- Stage k (0..STAGES−1) adds chunk k (bits k·CW+CW−1 : k·CW) plus the carry registered from stage k−1. Stage 0 uses carry-in = Sub.
- Higher-order operand chunks are skewed through delay registers; lower result chunks are deskewed so that all WIDTH bits arrive together at the output register.
- Sub, Signed and the valid bit travel with each operation through every stage.
- Overflow rules:
  - Signed=0, Sub=0: Overflow = Carry.
  - Signed=0, Sub=1: Overflow = ~Carry.
  - Signed=1: Overflow = (MSB of A == MSB of the B operand actually added) && (MSB of Sum ≠ that MSB). The B operand actually added is the inverted B for Sub.
- Saturation (SATURATE=1, only when Overflow=1):
  - Unsigned add: Sum = all-ones.
  - Unsigned sub: Sum = 0.
  - Signed: Sum = 2^(WIDTH−1)−1 if the true result is positive (A MSB = 0), else −2^(WIDTH−1).
  - Carry and Overflow are reported unchanged.
- Output register loads Sum/Carry/Overflow only when a valid operation leaves the last stage with En=1. Otherwise they hold their last value.
- OutValid is registered. It is 1 for exactly one enabled cycle per operation, and 0 after an enabled edge with a bubble.
- Bubbles (InValid=0) propagate as invalid slots. Data in invalid slots is don't-care but never reaches the outputs.

## Timing
- Latency: an operation sampled on enabled edge t appears on the outputs after the STAGES-th enabled edge counting t. For STAGES=1 this is the same edge, matching the legacy adder.
- Throughput: one operation per enabled cycle; no backpressure other than En.
- En=0: every register holds, including OutValid. A held OutValid=1 refers to the same result; there is no duplication or loss. Inputs are ignored while En=0.
- Reset: Rst_n low asynchronously clears all pipeline, valid and output registers. Sum=0, Carry=0, Overflow=0, OutValid=0 while Rst_n is low and until the first operation completes.
- Reset asserted mid-operation discards all in-flight operations. The first operation is accepted at the first enabled edge after Rst_n deasserts.
- InValid with En=0 on the same edge: the operation is not accepted.

## Test plan
All scenarios use WIDTH=8, STAGES=2 unless noted.
- Reset: issue an operation, assert Rst_n=0 one cycle later, asynchronously to Clk -> outputs 0 immediately; OutValid never pulses for the discarded operation.
- Unsigned add: A=200, B=100, Sub=0, Signed=0 -> after 2 enabled edges OutValid=1, Sum=44, Carry=1, Overflow=1; outputs hold after OutValid drops.
- Signed add/sub:
  - A=100, B=50, Signed=1 -> Sum=0x96, Carry=0, Overflow=1.
  - A=5, B=7, Sub=1, Signed=1 -> Sum=0xFE, Carry=0, Overflow=0.
  - Same operation with Signed=0 -> Overflow=1.
- Streaming with stall: tokens (1+2, 3+4, 255+1) on consecutive edges, with En=0 for 3 cycles after the second token -> results 3, 7, 0 (Carry=1) in order. Each OutValid is 1 for exactly one enabled cycle, with no gaps beyond the stall.
- Saturation, SATURATE=1:
  - Unsigned 200+100 -> 255.
  - Unsigned 5−7 -> 0.
  - Signed 100+50 -> 0x7F.
  - Signed −100−50 -> 0x80.
  - All with Overflow=1.
- Parameter sweep: STAGES ∈ {1, 2, 4, 8} at WIDTH=8 and STAGES=4 at WIDTH=32, with random operands and modes against a reference model -> bit-exact results, latency = STAGES.

Source files
------------

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract unit. The carry chain is cut into STAGES equal
// chunks, with optional saturation and unsigned/signed overflow reporting.
module adder_pipe #(
  parameter int WIDTH    = 8,
  parameter int STAGES   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic             InValid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             Signed,
  output logic             OutValid,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("adder_pipe: illegal WIDTH/STAGES combination");
  end

  // Stage k sees the operand bits still pending (chunks k and up) and the result
  // chunks already produced below it; each stage peels one chunk off the operands.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int HI = WIDTH - k * CW;

    logic [HI-1:0]       a_i;
    logic [HI-1:0]       b_i;
    logic                c_i;
    logic                v_i;
    logic                sub_i;
    logic                sgn_i;
    logic [CW:0]         chunk;
    logic [(k+1)*CW-1:0] res_o;
    logic                c_o;

    always_comb begin
      chunk = {1'b0, a_i[CW-1:0]} + {1'b0, b_i[CW-1:0]} + {{CW{1'b0}}, c_i};
      c_o   = chunk[CW];
    end

    if (k == 0) begin : g_in
      always_comb begin
        a_i   = A;
        b_i   = Sub ? ~B : B;
        c_i   = Sub;
        v_i   = InValid;
        sub_i = Sub;
        sgn_i = Signed;
        res_o = chunk[CW-1:0];
      end
    end else begin : g_in
      logic [HI-1:0]   a_q;
      logic [HI-1:0]   a_d;
      logic [HI-1:0]   b_q;
      logic [HI-1:0]   b_d;
      logic [k*CW-1:0] res_q;
      logic [k*CW-1:0] res_d;
      logic            c_q;
      logic            c_d;
      logic            v_q;
      logic            v_d;
      logic            sub_q;
      logic            sub_d;
      logic            sgn_q;
      logic            sgn_d;

      // Bubbles advance like real slots; only the valid bit decides whether they matter.
      always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        c_d   = c_q;
        v_d   = v_q;
        sub_d = sub_q;
        sgn_d = sgn_q;
        if (En) begin
          a_d   = g_st[k-1].a_i[HI+CW-1:CW];
          b_d   = g_st[k-1].b_i[HI+CW-1:CW];
          res_d = g_st[k-1].res_o;
          c_d   = g_st[k-1].c_o;
          v_d   = g_st[k-1].v_i;
          sub_d = g_st[k-1].sub_i;
          sgn_d = g_st[k-1].sgn_i;
        end
      end

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          res_q <= '0;
          c_q   <= 1'b0;
          v_q   <= 1'b0;
          sub_q <= 1'b0;
          sgn_q <= 1'b0;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          res_q <= res_d;
          c_q   <= c_d;
          v_q   <= v_d;
          sub_q <= sub_d;
          sgn_q <= sgn_d;
        end
      end

      always_comb begin
        a_i   = a_q;
        b_i   = b_q;
        c_i   = c_q;
        v_i   = v_q;
        sub_i = sub_q;
        sgn_i = sgn_q;
        res_o = {chunk[CW-1:0], res_q};
      end
    end
  end

  logic [WIDTH-1:0] last_sum;
  logic             last_carry;
  logic             last_v;
  logic             last_sub;
  logic             last_sgn;
  logic             a_msb;
  logic             b_msb;
  logic             ovf;
  logic [WIDTH-1:0] sum_sat;

  // b_msb is the MSB of the operand actually added, i.e. already inverted for Sub.
  always_comb begin
    last_sum   = g_st[LAST].res_o;
    last_carry = g_st[LAST].c_o;
    last_v     = g_st[LAST].v_i;
    last_sub   = g_st[LAST].sub_i;
    last_sgn   = g_st[LAST].sgn_i;
    a_msb      = g_st[LAST].a_i[CW-1];
    b_msb      = g_st[LAST].b_i[CW-1];
    if (last_sgn) begin
      ovf = (a_msb == b_msb) && (last_sum[WIDTH-1] != a_msb);
    end else begin
      ovf = last_sub ? ~last_carry : last_carry;
    end
    sum_sat = last_sum;
    if (SATURATE && ovf) begin
      if (last_sgn) begin
        sum_sat = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        sum_sat = last_sub ? '0 : '1;
      end
    end
  end

  logic             out_valid_q;
  logic             out_valid_d;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic             carry_d;
  logic             overflow_q;
  logic             overflow_d;

  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    if (En) begin
      out_valid_d = last_v;
      if (last_v) begin
        sum_d      = sum_sat;
        carry_d    = last_carry;
        overflow_d = ovf;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
    end
  end

  assign OutValid = out_valid_q;
  assign Sum      = sum_q;
  assign Carry    = carry_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: one shared operand stream feeds several adder_pipe configurations;
// each is compared against an arithmetic reference model with its own latency.
module tb_adder_pipe;

  localparam int NCFG = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            in_valid;
  logic            sub;
  logic            sgn;
  logic [31:0]     a_in;
  logic [31:0]     b_in;
  logic [NCFG-1:0] ov;
  logic [NCFG-1:0] cy;
  logic [NCFG-1:0] of;
  logic [4:0][7:0] sum8;
  logic [31:0]     sum32;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(8), .STAGES(2), .SATURATE(1'b0)) u_w8s2 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .InValid(in_valid), .A(a_in[7:0]), .B(b_in[7:0]),
    .Sub(sub), .Signed(sgn), .OutValid(ov[0]), .Sum(sum8[0]), .Carry(cy[0]), .Overflow(of[0]));

  adder_pipe #(.WIDTH(8), .STAGES(2), .SATURATE(1'b1)) u_w8s2_sat (
    .Clk(clk), .Rst_n(rst_n), .En(en), .InValid(in_valid), .A(a_in[7:0]), .B(b_in[7:0]),
    .Sub(sub), .Signed(sgn), .OutValid(ov[1]), .Sum(sum8[1]), .Carry(cy[1]), .Overflow(of[1]));

  adder_pipe #(.WIDTH(8), .STAGES(1), .SATURATE(1'b0)) u_w8s1 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .InValid(in_valid), .A(a_in[7:0]), .B(b_in[7:0]),
    .Sub(sub), .Signed(sgn), .OutValid(ov[2]), .Sum(sum8[2]), .Carry(cy[2]), .Overflow(of[2]));

  adder_pipe #(.WIDTH(8), .STAGES(4), .SATURATE(1'b0)) u_w8s4 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .InValid(in_valid), .A(a_in[7:0]), .B(b_in[7:0]),
    .Sub(sub), .Signed(sgn), .OutValid(ov[3]), .Sum(sum8[3]), .Carry(cy[3]), .Overflow(of[3]));

  adder_pipe #(.WIDTH(8), .STAGES(8), .SATURATE(1'b0)) u_w8s8 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .InValid(in_valid), .A(a_in[7:0]), .B(b_in[7:0]),
    .Sub(sub), .Signed(sgn), .OutValid(ov[4]), .Sum(sum8[4]), .Carry(cy[4]), .Overflow(of[4]));

  adder_pipe #(.WIDTH(32), .STAGES(4), .SATURATE(1'b0)) u_w32s4 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .InValid(in_valid), .A(a_in), .B(b_in),
    .Sub(sub), .Signed(sgn), .OutValid(ov[5]), .Sum(sum32), .Carry(cy[5]), .Overflow(of[5]));

  function automatic int cfgWidth(input int i);
    return (i == 5) ? 32 : 8;
  endfunction

  function automatic int cfgStages(input int i);
    case (i)
      2:       return 1;
      3:       return 4;
      4:       return 8;
      5:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic bit cfgSat(input int i);
    return (i == 1);
  endfunction

  function automatic logic [31:0] obsSum(input int i);
    if (i == 5) return sum32;
    return {24'd0, sum8[i]};
  endfunction

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        sgn;
  } op_t;

  op_t             hist[$];
  logic [NCFG-1:0] exp_v;
  logic [NCFG-1:0] exp_c;
  logic [NCFG-1:0] exp_o;
  logic [31:0]     exp_sum [NCFG];
  logic [31:0]     stream_q[$];
  int              checks = 0;
  int              errors = 0;

  // Reference result from plain integer arithmetic on the true values.
  function automatic void refModel(input int w, input bit sat, input op_t op,
                                   output logic [31:0] s, output logic c, output logic o);
    longint mask, ua, ub, sa, sb, tr, smax, smin, res;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(op.a) & mask;
    ub   = longint'(op.b) & mask;
    if (op.sub) begin
      c   = (ua >= ub);
      res = ua - ub;
    end else begin
      c   = ((ua + ub) > mask);
      res = ua + ub;
    end
    if (op.sgn) begin
      smax = (longint'(1) << (w - 1)) - 1;
      smin = -(longint'(1) << (w - 1));
      sa   = (ua > smax) ? ua - (mask + 1) : ua;
      sb   = (ub > smax) ? ub - (mask + 1) : ub;
      tr   = op.sub ? sa - sb : sa + sb;
      o    = (tr > smax) || (tr < smin);
      if (sat && tr > smax) res = smax;
      else if (sat && tr < smin) res = smin;
    end else begin
      o = op.sub ? (ua < ub) : ((ua + ub) > mask);
      if (sat && o) res = op.sub ? 64'sd0 : mask;
    end
    s = 32'(res & mask);
  endfunction

  task automatic modelEdge();
    op_t cur;
    int  idx;
    if (!rst_n) begin
      hist.delete();
      exp_v = '0;
      exp_c = '0;
      exp_o = '0;
      for (int i = 0; i < NCFG; i++) exp_sum[i] = '0;
    end else if (en) begin
      cur.v   = in_valid;
      cur.a   = a_in;
      cur.b   = b_in;
      cur.sub = sub;
      cur.sgn = sgn;
      hist.push_back(cur);
      for (int i = 0; i < NCFG; i++) begin
        idx = hist.size() - cfgStages(i);
        if (idx >= 0 && hist[idx].v) begin
          refModel(cfgWidth(i), cfgSat(i), hist[idx], exp_sum[i], exp_c[i], exp_o[i]);
          exp_v[i] = 1'b1;
        end else begin
          exp_v[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string where);
    for (int i = 0; i < NCFG; i++) begin
      checkOutput($sformatf("%s cfg%0d OutValid", where, i), 32'(ov[i]), 32'(exp_v[i]));
      checkOutput($sformatf("%s cfg%0d Sum", where, i), obsSum(i), exp_sum[i]);
      checkOutput($sformatf("%s cfg%0d Carry", where, i), 32'(cy[i]), 32'(exp_c[i]));
      checkOutput($sformatf("%s cfg%0d Overflow", where, i), 32'(of[i]), 32'(exp_o[i]));
    end
  endtask

  task automatic checkConst(input int cfg, input string tag, input logic [31:0] s,
                            input logic c, input logic o);
    checkOutput({tag, " OutValid"}, 32'(ov[cfg]), 32'd1);
    checkOutput({tag, " Sum"}, obsSum(cfg), s);
    checkOutput({tag, " Carry"}, 32'(cy[cfg]), 32'(c));
    checkOutput({tag, " Overflow"}, 32'(of[cfg]), 32'(o));
  endtask

  task automatic applyStimulus(input logic t_en, input logic t_v, input logic [31:0] t_a,
                               input logic [31:0] t_b, input logic t_sub, input logic t_sgn,
                               input string where);
    @(negedge clk);
    en       = t_en;
    in_valid = t_v;
    a_in     = t_a;
    b_in     = t_b;
    sub      = t_sub;
    sgn      = t_sgn;
    @(posedge clk);
    #1;
    modelEdge();
    checkAll(where);
  endtask

  task automatic runOp(input logic [31:0] t_a, input logic [31:0] t_b, input logic t_sub,
                       input logic t_sgn, input string where);
    applyStimulus(1'b1, 1'b1, t_a, t_b, t_sub, t_sgn, where);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, where);
  endtask

  // Reset lands mid-cycle, well away from any clock edge.
  task automatic asyncReset(input string where);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    modelEdge();
    checkAll(where);
  endtask

  task automatic releaseReset(input string where);
    @(negedge clk);
    rst_n    = 1'b1;
    en       = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    modelEdge();
    checkAll(where);
  endtask

  task automatic collectStream();
    if (en && ov[0]) stream_q.push_back({23'd0, cy[0], sum8[0]});
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n    = 1'b1;
    en       = 1'b0;
    in_valid = 1'b0;
    a_in     = '0;
    b_in     = '0;
    sub      = 1'b0;
    sgn      = 1'b0;
    #1 rst_n = 1'b0;
    $display("[TB] reset state");
    applyStimulus(1'b1, 1'b1, 32'd9, 32'd9, 1'b0, 1'b0, "reset hold");
    applyStimulus(1'b1, 1'b1, 32'd3, 32'd4, 1'b1, 1'b1, "reset hold");
    releaseReset("release");

    $display("[TB] directed arithmetic");
    runOp(32'd200, 32'd100, 1'b0, 1'b0, "uadd");
    checkConst(0, "uadd", 32'd44, 1'b1, 1'b1);
    checkConst(1, "uadd sat", 32'd255, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "uadd hold");
    checkOutput("uadd hold OutValid", 32'(ov[0]), 32'd0);
    checkOutput("uadd hold Sum", obsSum(0), 32'd44);

    runOp(32'd100, 32'd50, 1'b0, 1'b1, "sadd");
    checkConst(0, "sadd", 32'h96, 1'b0, 1'b1);
    checkConst(1, "sadd sat", 32'h7F, 1'b0, 1'b1);

    runOp(32'd5, 32'd7, 1'b1, 1'b1, "ssub");
    checkConst(0, "ssub", 32'hFE, 1'b0, 1'b0);
    checkConst(1, "ssub sat", 32'hFE, 1'b0, 1'b0);

    runOp(32'd5, 32'd7, 1'b1, 1'b0, "usub");
    checkConst(0, "usub", 32'hFE, 1'b0, 1'b1);
    checkConst(1, "usub sat", 32'h00, 1'b0, 1'b1);

    runOp(32'h9C, 32'd50, 1'b1, 1'b1, "sneg");
    checkConst(0, "sneg", 32'h6A, 1'b1, 1'b1);
    checkConst(1, "sneg sat", 32'h80, 1'b1, 1'b1);

    $display("[TB] async reset with operation in flight");
    applyStimulus(1'b1, 1'b1, 32'd7, 32'd8, 1'b0, 1'b0, "pre reset");
    asyncReset("async reset");
    checkOutput("async reset Sum", obsSum(0), 32'd0);
    checkOutput("async reset OutValid", 32'(ov[0]), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'd1, 32'd1, 1'b0, 1'b0, "in reset");
    releaseReset("post reset release");
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "post reset idle");

    $display("[TB] streaming with stall");
    stream_q.delete();
    applyStimulus(1'b1, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0, "stream t1");
    collectStream();
    applyStimulus(1'b1, 1'b1, 32'd3, 32'd4, 1'b0, 1'b0, "stream t2");
    collectStream();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0, "stream stall");
      checkOutput("stream stall OutValid", 32'(ov[0]), 32'd1);
      checkOutput("stream stall Sum", obsSum(0), 32'd3);
    end
    applyStimulus(1'b1, 1'b1, 32'd255, 32'd1, 1'b0, 1'b0, "stream t3");
    collectStream();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "stream drain");
      collectStream();
    end
    checkOutput("stream count", 32'(stream_q.size()), 32'd3);
    checkOutput("stream r0", (stream_q.size() > 0) ? stream_q[0] : 32'hDEAD_BEEF, 32'h003);
    checkOutput("stream r1", (stream_q.size() > 1) ? stream_q[1] : 32'hDEAD_BEEF, 32'h007);
    checkOutput("stream r2", (stream_q.size() > 2) ? stream_q[2] : 32'hDEAD_BEEF, 32'h100);

    $display("[TB] random sweep");
    for (int n = 0; n < 400; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 5 == 0) begin
        case ($urandom_range(0, 3))
          0:       ra = 32'h0000_0000;
          1:       ra = 32'hFFFF_FFFF;
          2:       ra = 32'h8000_0080;
          default: ra = 32'h7FFF_FF7F;
        endcase
      end
      if (n == 200) begin
        asyncReset("random reset");
        releaseReset("random release");
      end
      applyStimulus(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0), ra, rb,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "final drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
